// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizes for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 32;
  localparam int CW_DEF   = 16;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - requester beats in, FIFO write port out
interface fifo_wr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic                    fifo_full;
  logic                    fifo_wen;
  logic [DW-1:0]           fifo_din;
  logic [SRC_W-1:0]        fifo_src;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wen, fifo_din, fifo_src
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wen, fifo_din, fifo_src
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - first valid requester searching upward from rr_ptr with wrap
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 2
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!any && valid[c]) begin
        idx = SRC_W'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - packet-atomic round-robin arbiter merging requesters into one FIFO
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fifo_wr_arb_if.slave            bus,
  input  logic                    cnt_clr,
  output logic [NREQ-1:0][CW-1:0] beat_cnt
);

  localparam int SRC_W = $clog2(NREQ);

  arb_state_e              state_q, state_d;
  logic [SRC_W-1:0]        owner_q, owner_d;
  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0][CW-1:0] cnt_q, cnt_d;

  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic [SRC_W-1:0] grant;
  logic             grant_vld;
  logic             xfer;

  rr_pick #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .valid  (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Once locked the owner keeps the grant even through bubbles, so packets never interleave.
  always_comb begin
    grant     = (state_q == LOCKED) ? owner_q : pick_idx;
    grant_vld = (state_q == LOCKED) | pick_any;
    xfer      = rst_n & grant_vld & bus.req_valid[grant] & ~bus.fifo_full;
  end

  always_comb begin
    bus.req_ready = '0;
    bus.fifo_wen  = xfer;
    bus.fifo_din  = '0;
    bus.fifo_src  = '0;
    if (xfer) begin
      bus.req_ready[grant] = 1'b1;
      bus.fifo_din         = bus.req_data[grant];
      bus.fifo_src         = grant;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      if (bus.req_last[grant]) begin
        state_d  = IDLE;
        rr_ptr_d = (grant == SRC_W'(NREQ - 1)) ? '0 : grant + SRC_W'(1);
      end else begin
        state_d = LOCKED;
        owner_d = grant;
      end
    end
    // Clear takes priority over a same-cycle beat.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q[grant] != '1)) begin
      cnt_d[grant] = cnt_q[grant] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb against a rule-level reference model
module tb_fifo_wr_arb;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SW = 2;

  typedef logic [N-1:0][DW-1:0] data_t;

  typedef struct packed {
    logic                 wen;
    logic [N-1:0]         rdy;
    logic [SW-1:0]        src;
    logic [DW-1:0]        din;
    logic [N-1:0][CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] din;
    logic [N-1:0]  rdy;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;
  logic [N-1:0][CW-1:0] beat_cnt;

  fifo_wr_arb_if #(.NREQ(N), .DW(DW)) bus ();

  fifo_wr_arb #(.NREQ(N), .DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cnt_clr  (cnt_clr),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t expq[$];
  wr_t  wlog[$];

  bit m_locked = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt[N];

  bit            open_pkt = 0;
  logic [SW-1:0] open_src = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict the response from arbitration rules, then advance the model.
  task automatic step(input logic [N-1:0] v, input data_t d, input logic [N-1:0] l,
                      input logic full, input logic clr, input logic rn);
    exp_t e;
    int   g;
    bit   found;
    bit   x;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.fifo_full = full;
    cnt_clr       = clr;
    rst_n         = rn;
    e = '0;
    g = 0;
    found = 0;
    if (m_locked) begin
      g = m_owner;
      found = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_ptr + k) % N]) begin
          g = (m_ptr + k) % N;
          found = 1;
        end
      end
    end
    x = rn && found && v[g] && !full;
    for (int i = 0; i < N; i++) e.cnt[i] = CW'(m_cnt[i]);
    if (x) begin
      e.wen    = 1'b1;
      e.rdy[g] = 1'b1;
      e.src    = SW'(g);
      e.din    = d[g];
    end
    expq.push_back(e);
    if (!rn) begin
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (x) begin
        if (l[g]) begin
          m_locked = 0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked = 1;
          m_owner  = g;
        end
      end
      if (clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (x && m_cnt[g] < (1 << CW) - 1) begin
        m_cnt[g]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic data_t mk(input logic [DW-1:0] base);
    data_t d;
    for (int i = 0; i < N; i++) d[i] = base + DW'(i);
    return d;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("fifo_wen", 64'(bus.fifo_wen), 64'(e.wen));
      chk("req_ready", 64'(bus.req_ready), 64'(e.rdy));
      chk("fifo_src", 64'(bus.fifo_src), 64'(e.src));
      chk("fifo_din", 64'(bus.fifo_din), 64'(e.din));
      chk("beat_cnt", 64'(beat_cnt), 64'(e.cnt));
      chk("wen_while_full", 64'(bus.fifo_wen & bus.fifo_full), 64'(0));
      if (!rst_n) open_pkt = 0;
      if (bus.fifo_wen) begin
        if (open_pkt) chk("interleave", 64'(bus.fifo_src), 64'(open_src));
        open_pkt = !bus.req_last[bus.fifo_src];
        open_src = bus.fifo_src;
        wlog.push_back('{src: bus.fifo_src, din: bus.fifo_din, rdy: bus.req_ready});
      end
    end
  end

  initial begin
    data_t d;
    logic [N-1:0] v;
    logic [N-1:0] l;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_beat_cnt", 64'(beat_cnt), 64'(0));
    chk("reset_wen", 64'(bus.fifo_wen), 64'(0));
    step('0, '0, '0, 1'b0, 1'b0, 1'b0);

    // All four valid with single-beat packets: strict rotation, pointer wraps to 0.
    wlog.delete();
    for (int c = 0; c < 5; c++) step(4'hF, mk(32'h1000 + 32'(c * 16)), 4'hF, 1'b0, 1'b0, 1'b1);
    chk("rot_count", 64'(wlog.size()), 64'(5));
    if (wlog.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("rot_src", 64'(wlog[i].src), 64'(i));
      chk("rot_wrap_src", 64'(wlog[4].src), 64'(0));
    end

    // Requester 1 sends A,B,C while requester 0 waits.
    wlog.delete();
    d = mk(32'h200);
    d[1] = 32'hA;
    step(4'b0011, d, 4'b0001, 1'b0, 1'b0, 1'b1);
    d[1] = 32'hB;
    step(4'b0011, d, 4'b0001, 1'b0, 1'b0, 1'b1);
    d[1] = 32'hC;
    step(4'b0011, d, 4'b0011, 1'b0, 1'b0, 1'b1);
    step(4'b0001, d, 4'b0001, 1'b0, 1'b0, 1'b1);
    chk("pkt_count", 64'(wlog.size()), 64'(4));
    if (wlog.size() == 4) begin
      chk("pkt_a", 64'({wlog[0].src, wlog[0].din}), 64'({2'd1, 32'hA}));
      chk("pkt_b", 64'({wlog[1].src, wlog[1].din}), 64'({2'd1, 32'hB}));
      chk("pkt_c", 64'({wlog[2].src, wlog[2].din}), 64'({2'd1, 32'hC}));
      chk("pkt_rdy", 64'(wlog[1].rdy), 64'(4'b0010));
      chk("pkt_then_req0", 64'(wlog[3].src), 64'(0));
    end

    // Full stalls the second beat of a requester-2 packet; lock must survive.
    wlog.delete();
    d = mk(32'h300);
    d[2] = 32'h21;
    step(4'b0100, d, 4'b0000, 1'b0, 1'b0, 1'b1);
    d[2] = 32'h22;
    for (int c = 0; c < 3; c++) step(4'b1111, d, 4'b1011, 1'b1, 1'b0, 1'b1);
    chk("stall_count", 64'(wlog.size()), 64'(1));
    step(4'b1111, d, 4'b1011, 1'b0, 1'b0, 1'b1);
    d[2] = 32'h23;
    step(4'b1111, d, 4'b1111, 1'b0, 1'b0, 1'b1);
    chk("full_count", 64'(wlog.size()), 64'(3));
    if (wlog.size() == 3) begin
      chk("full_b2", 64'({wlog[1].src, wlog[1].din}), 64'({2'd2, 32'h22}));
      chk("full_b3", 64'({wlog[2].src, wlog[2].din}), 64'({2'd2, 32'h23}));
    end

    // Counter saturation at 15 and clear beating a same-cycle transfer.
    step('0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) step(4'b1000, mk(32'h400 + 32'(c)), 4'b1000, 1'b0, 1'b0, 1'b1);
    chk("cnt_sat", 64'(beat_cnt[3]), 64'(15));
    step(4'b1000, mk(32'h500), 4'b1000, 1'b0, 1'b1, 1'b1);
    chk("cnt_clr_wins", 64'(beat_cnt[3]), 64'(0));
    step(4'b1000, mk(32'h510), 4'b1000, 1'b0, 1'b0, 1'b1);
    chk("cnt_after_clr", 64'(beat_cnt[3]), 64'(1));

    // Reset while locked on requester 2 drops the lock.
    wlog.delete();
    step(4'b0100, mk(32'h600), 4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b1111, mk(32'h610), 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1111, mk(32'h620), 4'b1111, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) chk("rst_req0_first", 64'(wlog[1].src), 64'(0));

    for (int c = 0; c < 3000; c++) begin
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        l[i] = ($urandom_range(3) == 0);
        d[i] = $urandom;
      end
      step(v, d, l, ($urandom_range(3) == 0), ($urandom_range(99) == 0),
           ($urandom_range(199) != 0));
    end

    chk("scoreboard_drained", 64'(expq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DW, default 32, data width, matching the FIFO data width.
REQ-003 SHALL have parameter CW, default 16, per-requester beat-counter width.
REQ-004 SHALL have input clk (1 bit), the clock; all state updates on its rising edge.
REQ-005 SHALL have input rst_n (1 bit), reset; synchronous, active-low.
REQ-006 SHALL have input req_valid (NREQ bits), per-requester beat valid.
REQ-007 SHALL have input req_data (NREQ x DW bits), per-requester beat data.
REQ-008 SHALL have input req_last (NREQ bits), per-requester end-of-packet marker.
REQ-009 SHALL have output req_ready (NREQ bits), per-requester beat accepted this cycle.
REQ-010 SHALL have input fifo_full (1 bit), the FIFO full flag.
REQ-011 SHALL have output fifo_wen (1 bit), the FIFO write enable.
REQ-012 SHALL have output fifo_din (DW bits), the FIFO write data.
REQ-013 SHALL have output fifo_src (SRC_W = clog2(NREQ) bits), index of the granted requester.
REQ-014 SHALL have input cnt_clr (1 bit), synchronous clear of all beat counters.
REQ-015 SHALL have output beat_cnt (NREQ x CW bits), per-requester accepted-beat counters.

Function
REQ-016 SHALL arbitrate packets atomically: beats from different requesters never interleave in the FIFO.
REQ-017 SHALL use FSM states IDLE and LOCKED, plus registers owner (SRC_W bits) and rr_ptr (SRC_W bits).
REQ-018 In IDLE, the grant SHALL go combinationally to the first requester with req_valid=1, searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
REQ-019 In LOCKED, the grant SHALL go only to owner; other requesters get req_ready=0 even when valid.
REQ-020 A beat SHALL transfer when the granted requester has req_valid=1 and fifo_full=0.
REQ-021 On a transfer: req_ready[grant]=1, fifo_wen=1, fifo_din=req_data[grant], fifo_src=grant, all in the same cycle (zero latency).
REQ-022 With no transfer, fifo_wen=0 and all req_ready=0; fifo_din and fifo_src SHALL be 0.
REQ-023 IDLE to LOCKED SHALL occur on a transfer with req_last=0; owner takes the grant index.
REQ-024 On a transfer with req_last=1 from either state: next state IDLE, rr_ptr takes (grant+1) mod NREQ.
REQ-025 A single-beat packet (last=1 in IDLE) SHALL stay in IDLE and advance rr_ptr.
REQ-026 fifo_full=1 SHALL stall the transfer with no state, owner or rr_ptr change; in LOCKED, the lock SHALL be held.
REQ-027 In LOCKED, owner dropping req_valid SHALL hold the lock (bubble); no other requester is served.
REQ-028 beat_cnt[i] SHALL increment on each transfer from requester i and saturate at 2^CW-1.
REQ-029 cnt_clr=1 SHALL zero all counters next cycle; a simultaneous transfer SHALL not be counted (clear wins).
REQ-030 fifo_wen SHALL never be 1 while fifo_full=1.

Reset
REQ-031 On rst_n=0 at a clock edge: state IDLE, owner 0, rr_ptr 0, all beat_cnt 0.
REQ-032 While rst_n=0, req_ready, fifo_wen, fifo_din and fifo_src SHALL be 0.
REQ-033 Reset mid-packet SHALL abandon the lock; no partial-packet recovery.

Structure
REQ-034 Package fifo_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the default NREQ/DW/CW constants.
REQ-035 Sub-module rr_pick SHALL implement the rotate-priority search (inputs valid vector and rr_ptr; outputs index and any flag).
REQ-036 Outputs toward the FIFO SHALL be combinational from state and inputs; state, owner, rr_ptr and counters SHALL be registered.

Verification
REQ-037 Bench SHALL cover: after reset, all 4 valid with last=1, fifo_full=0 for 4 cycles -> fifo_src sequence 0,1,2,3; rr_ptr returns to 0.
REQ-038 Bench SHALL cover: req1 sends a 3-beat packet (A,B,C; last on C) while req0 is valid throughout -> FIFO receives A,B,C with src=1, then req0 is served; req0 ready=0 during the packet.
REQ-039 Bench SHALL cover: fifo_full=1 during the 2nd beat of a req2 packet for 3 cycles -> fifo_wen=0 for those cycles, lock held, the 2nd beat written on the first cycle with full=0.
REQ-040 Bench SHALL cover: CW=4 with 20 accepted beats from req3 -> beat_cnt[3]=15; cnt_clr in the same cycle as a transfer -> counter 0 next cycle.
REQ-041 Bench SHALL cover: rst_n=0 while LOCKED on owner 2 -> next cycle IDLE, req0 granted first if valid.
REQ-042 Bench SHALL check the REQ-030 invariant and no interleaving (by fifo_src and last) on every cycle of a random-traffic run.
